// File: rtl/riscv_pkg.sv
// riscv_pkg: definitions shared by the RV32 pipeline stages.
//   XLEN, REG_ADDR_W        datapath / register-address widths
//   ALU_*                   4-bit ALU opcodes
//   ex_regs_t               contents of the ID/EX pipeline register
//   EX_BUBBLE               reset/bubble value of ex_regs_t (ADD 0+0, no side effects)
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SLL  = 4'b0011;
    localparam logic [3:0] ALU_SLT  = 4'b0100;
    localparam logic [3:0] ALU_SLTU = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_XOR  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;
    localparam logic [3:0] ALU_LUI  = 4'b1111;

    typedef struct packed {
        logic                  valid;
        logic [XLEN-1:0]       pc;
        logic [XLEN-1:0]       rs1_data;
        logic [XLEN-1:0]       rs2_data;
        logic [XLEN-1:0]       imm;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic [REG_ADDR_W-1:0] rd;
        logic [3:0]            alu_sel;
        logic                  src_imm;
        logic                  src_pc;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_regs_t;

    localparam ex_regs_t EX_BUBBLE = '{
        valid:     1'b0,
        pc:        '0,
        rs1_data:  '0,
        rs2_data:  '0,
        imm:       '0,
        rs1:       '0,
        rs2:       '0,
        rd:        '0,
        alu_sel:   ALU_ADD,
        src_imm:   1'b0,
        src_pc:    1'b0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        mem_write: 1'b0,
        mem_to_reg: 1'b0
    };

endpackage

// File: rtl/ex_forward_mux.sv
// ex_forward_mux: selects one ALU source operand from the newest producer.
//   rs            source register address of the EX instruction
//   reg_data      value captured from the register file in ID
//   exmem_*       EX/MEM producer (write enable, destination, value)
//   memwb_*       MEM/WB producer (write enable, destination, value)
//   fwd_data      forwarded operand
// EX/MEM is younger than MEM/WB, so it wins when both match. x0 is never
// forwarded since writes to it are discarded by the register file.
module ex_forward_mux
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic [XLEN-1:0]       reg_data,
    input  logic                  exmem_reg_write,
    input  logic [REG_ADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]       exmem_result,
    input  logic                  memwb_reg_write,
    input  logic [REG_ADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]       memwb_result,
    output logic [XLEN-1:0]       fwd_data
);

    logic hit_exmem;
    logic hit_memwb;

    assign hit_exmem = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs);
    assign hit_memwb = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs);

    always_comb begin
        fwd_data = reg_data;
        if (hit_exmem)      fwd_data = exmem_result;
        else if (hit_memwb) fwd_data = memwb_result;
    end

endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and
// load-use hazard detection.
//   clk, rst_n          clock, synchronous active-low reset
//   stall, flush        downstream freeze / taken branch
//   id_*                decoded instruction from ID
//   exmem_*, memwb_*    forwarding sources
//   alu_dataA/B, alu_sel  ALU operands (A/B combinational) and opcode
//   ex_*                registered controls carried to EX/MEM
//   ex_store_data       forwarded rs2 for stores
//   load_use_hazard     hold request to IF/ID and PC
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs1_data,
    input  logic [31:0] id_rs2_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [3:0]  id_alu_sel,
    input  logic        id_src_imm,
    input  logic        id_src_pc,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_mem_write,
    input  logic        id_mem_to_reg,
    input  logic        exmem_reg_write,
    input  logic [4:0]  exmem_rd,
    input  logic [31:0] exmem_result,
    input  logic        memwb_reg_write,
    input  logic [4:0]  memwb_rd,
    input  logic [31:0] memwb_result,
    output logic [31:0] alu_dataA,
    output logic [31:0] alu_dataB,
    output logic [3:0]  alu_sel,
    output logic        ex_valid,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write,
    output logic        ex_mem_to_reg,
    output logic [4:0]  ex_rd,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_store_data,
    output logic        load_use_hazard
);

    ex_regs_t        ex_q;
    ex_regs_t        id_d;
    logic [XLEN-1:0] fwd_a;
    logic [XLEN-1:0] fwd_b;

    assign id_d = '{
        valid:      id_valid,
        pc:         id_pc,
        rs1_data:   id_rs1_data,
        rs2_data:   id_rs2_data,
        imm:        id_imm,
        rs1:        id_rs1,
        rs2:        id_rs2,
        rd:         id_rd,
        alu_sel:    id_alu_sel,
        src_imm:    id_src_imm,
        src_pc:     id_src_pc,
        reg_write:  id_reg_write,
        mem_read:   id_mem_read,
        mem_write:  id_mem_write,
        mem_to_reg: id_mem_to_reg
    };

    // rs2 is compared even when ID is I-type; a spurious bubble is cheaper
    // than decoding the format here.
    assign load_use_hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && id_valid &&
                             ((ex_q.rd == id_rs1) || (ex_q.rd == id_rs2));

    // While frozen, the operand copies keep absorbing forwarded values so a
    // producer that leaves MEM/WB during the freeze is not lost. A flush or
    // hazard during a stall is deliberately ignored: stall has priority.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= EX_BUBBLE;
        end else if (stall) begin
            ex_q.rs1_data <= fwd_a;
            ex_q.rs2_data <= fwd_b;
        end else if (flush || load_use_hazard) begin
            ex_q <= EX_BUBBLE;
        end else begin
            ex_q <= id_d;
        end
    end

    ex_forward_mux u_fwd_a (
        .rs              (ex_q.rs1),
        .reg_data        (ex_q.rs1_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_a)
    );

    ex_forward_mux u_fwd_b (
        .rs              (ex_q.rs2),
        .reg_data        (ex_q.rs2_data),
        .exmem_reg_write (exmem_reg_write),
        .exmem_rd        (exmem_rd),
        .exmem_result    (exmem_result),
        .memwb_reg_write (memwb_reg_write),
        .memwb_rd        (memwb_rd),
        .memwb_result    (memwb_result),
        .fwd_data        (fwd_b)
    );

    assign alu_dataA     = ex_q.src_pc  ? ex_q.pc  : fwd_a;
    assign alu_dataB     = ex_q.src_imm ? ex_q.imm : fwd_b;
    assign ex_store_data = fwd_b;

    assign alu_sel       = ex_q.alu_sel;
    assign ex_valid      = ex_q.valid;
    assign ex_reg_write  = ex_q.reg_write;
    assign ex_mem_read   = ex_q.mem_read;
    assign ex_mem_write  = ex_q.mem_write;
    assign ex_mem_to_reg = ex_q.mem_to_reg;
    assign ex_rd         = ex_q.rd;
    assign ex_pc         = ex_q.pc;

endmodule
